// File: rtl/evm_pkg.sv
// Shared types and constants for the EVM ballot input front-end.
package evm_pkg;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_IDLE     = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_ARMED    = 3'd3,
    ST_COOLDOWN = 3'd4,
    ST_DONE     = 3'd5
  } evm_state_e;

  // Candidate indices, matching the evm candidate_name encoding.
  localparam logic [1:0] CAND_NONE = 2'b00;
  localparam logic [1:0] CAND_1    = 2'b01;
  localparam logic [1:0] CAND_2    = 2'b10;
  localparam logic [1:0] CAND_3    = 2'b11;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
  localparam int unsigned ARM_TIMEOUT_DEF     = 90;

  // Number of candidate buttons pressed in the same cycle.
  function automatic logic [1:0] cand_count(input logic [2:0] p);
    return 2'(p[0]) + 2'(p[1]) + 2'(p[2]);
  endfunction

  // Candidate index for a one-hot press vector; CAND_NONE otherwise.
  function automatic logic [1:0] cand_index(input logic [2:0] p);
    logic [1:0] idx;
    idx = CAND_NONE;
    case (p)
      3'b001:  idx = CAND_1;
      3'b010:  idx = CAND_2;
      3'b100:  idx = CAND_3;
      default: idx = CAND_NONE;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronises, debounces and edge-detects one raw panel button.
module button_debouncer
  import evm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db,
  output logic press
);

  localparam int unsigned CNT_W = 8;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             db_q, db_d;
  logic             db_r_q, db_r_d;
  logic             db_prev_q, db_prev_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state: two-flop sync, stability counter, rising-edge detect on a retimed db.
  always_comb begin
    sync1_d   = raw;
    sync2_d   = sync1_q;
    db_d      = db_q;
    cnt_d     = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    db_r_d    = db_q;
    db_prev_d = db_r_q;
    press_d   = db_r_q & ~db_prev_q;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_q      <= 1'b0;
      db_r_q    <= 1'b0;
      db_prev_q <= 1'b0;
      press_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_q      <= db_d;
      db_r_q    <= db_r_d;
      db_prev_q <= db_prev_d;
      press_q   <= press_d;
      cnt_q     <= cnt_d;
    end
  end

  assign db    = db_q;
  assign press = press_q;

endmodule

// File: rtl/ballot_input_conditioner.sv
// Turns raw EVM panel buttons into clean, single-cycle ballot strobes.
module ballot_input_conditioner
  import evm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned ARM_TIMEOUT     = ARM_TIMEOUT_DEF,
  parameter int unsigned WIDTH           = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             switch_on_evm,
  input  logic             officer_btn_raw,
  input  logic [2:0]       cand_btn_raw,
  input  logic             end_btn_raw,
  output logic             candidate_ready,
  output logic             vote_candidate_1,
  output logic             vote_candidate_2,
  output logic             vote_candidate_3,
  output logic             voting_session_done,
  output logic             ballot_armed,
  output logic             multi_press_err,
  output logic             ballot_timeout,
  output logic [WIDTH-1:0] ballots_cast
);

  localparam int unsigned TIMER_W = 7;

  logic       officer_db, officer_press;
  logic [2:0] cand_db, cand_press;
  logic       unused_end_db, end_press;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_officer (
    .clk(clk), .rst(rst), .raw(officer_btn_raw), .db(officer_db), .press(officer_press)
  );

  for (genvar i = 0; i < 3; i++) begin : g_cand
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_cand (
      .clk(clk), .rst(rst), .raw(cand_btn_raw[i]), .db(cand_db[i]), .press(cand_press[i])
    );
  end

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_end (
    .clk(clk), .rst(rst), .raw(end_btn_raw), .db(unused_end_db), .press(end_press)
  );

  evm_state_e       state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [WIDTH-1:0] cast_q, cast_d;
  logic             ready_q, ready_d;
  logic             vote1_q, vote1_d;
  logic             vote2_q, vote2_d;
  logic             vote3_q, vote3_d;
  logic             done_q, done_d;
  logic             armed_q, armed_d;
  logic             merr_q, merr_d;
  logic             tmo_q, tmo_d;
  logic [1:0]       n_press;
  logic [1:0]       sel;

  // Ballot FSM: next state, timer, vote counter and next-cycle strobes.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cast_d  = cast_q;
    ready_d = 1'b0;
    vote1_d = 1'b0;
    vote2_d = 1'b0;
    vote3_d = 1'b0;
    done_d  = 1'b0;
    merr_d  = 1'b0;
    tmo_d   = 1'b0;
    n_press = cand_count(cand_press);
    sel     = cand_index(cand_press);

    if (!switch_on_evm) begin
      state_d = ST_OFF;
      timer_d = '0;
      cast_d  = '0;
    end else begin
      case (state_q)
        ST_OFF: state_d = ST_IDLE;
        ST_IDLE: begin
          if (officer_press) begin
            state_d = ST_ISSUE;
            ready_d = 1'b1;
          end else if (end_press) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
        ST_ISSUE: begin
          timer_d = '0;
          state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (n_press == 2'd1) begin
            vote1_d = (sel == CAND_1);
            vote2_d = (sel == CAND_2);
            vote3_d = (sel == CAND_3);
            if (~&cast_q) cast_d = cast_q + WIDTH'(1);
            state_d = ST_COOLDOWN;
          end else begin
            merr_d = (n_press >= 2'd2);
            if (timer_q == TIMER_W'(ARM_TIMEOUT - 1)) begin
              tmo_d   = 1'b1;
              state_d = ST_IDLE;
            end else begin
              timer_d = timer_q + TIMER_W'(1);
            end
          end
        end
        ST_COOLDOWN: begin
          if (cand_db == 3'b000 && !officer_db) state_d = ST_IDLE;
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_OFF;
      endcase
    end
    armed_d = (state_d == ST_ARMED);
  end

  // FSM and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_OFF;
      timer_q <= '0;
      cast_q  <= '0;
      ready_q <= 1'b0;
      vote1_q <= 1'b0;
      vote2_q <= 1'b0;
      vote3_q <= 1'b0;
      done_q  <= 1'b0;
      armed_q <= 1'b0;
      merr_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cast_q  <= cast_d;
      ready_q <= ready_d;
      vote1_q <= vote1_d;
      vote2_q <= vote2_d;
      vote3_q <= vote3_d;
      done_q  <= done_d;
      armed_q <= armed_d;
      merr_q  <= merr_d;
      tmo_q   <= tmo_d;
    end
  end

  assign candidate_ready     = ready_q;
  assign vote_candidate_1    = vote1_q;
  assign vote_candidate_2    = vote2_q;
  assign vote_candidate_3    = vote3_q;
  assign voting_session_done = done_q;
  assign ballot_armed        = armed_q;
  assign multi_press_err     = merr_q;
  assign ballot_timeout      = tmo_q;
  assign ballots_cast        = cast_q;

endmodule

// File: tb/tb_ballot_input_conditioner.sv
// Scoreboard bench: a cycle-level reference model predicts every output word.
module tb_ballot_input_conditioner;

  localparam int D = 4;
  localparam int T = 90;

  logic       clk = 1'b0;
  logic       rst;
  logic       switch_on_evm;
  logic       officer_btn_raw;
  logic [2:0] cand_btn_raw;
  logic       end_btn_raw;
  logic       candidate_ready, vote_candidate_1, vote_candidate_2, vote_candidate_3;
  logic       voting_session_done, ballot_armed, multi_press_err, ballot_timeout;
  logic [6:0] ballots_cast;

  always #5 clk = ~clk;

  ballot_input_conditioner dut (
    .clk(clk), .rst(rst), .switch_on_evm(switch_on_evm),
    .officer_btn_raw(officer_btn_raw), .cand_btn_raw(cand_btn_raw), .end_btn_raw(end_btn_raw),
    .candidate_ready(candidate_ready), .vote_candidate_1(vote_candidate_1),
    .vote_candidate_2(vote_candidate_2), .vote_candidate_3(vote_candidate_3),
    .voting_session_done(voting_session_done), .ballot_armed(ballot_armed),
    .multi_press_err(multi_press_err), .ballot_timeout(ballot_timeout),
    .ballots_cast(ballots_cast)
  );

  typedef struct packed {
    logic       cr, v1, v2, v3, done, armed, merr, tmo;
    logic [6:0] cast;
  } out_t;

  out_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model. Button index: 0 officer, 1..3 candidates 1..3, 4 end.
  typedef enum int {P_OFF, P_IDLE, P_ISSUE, P_ARMED, P_COOL, P_DONE} phase_e;
  phase_e m_phase = P_OFF;
  int     m_age   = 0;
  int     m_votes = 0;
  bit     m_s1[5], m_s[5], m_db[5], m_d1[5], m_d2[5], m_press[5];
  int     m_cnt[5];

  task automatic model_step(input bit r, input bit sw, input bit [4:0] raw);
    out_t o;
    int   n;
    bit   old_db, old_d1;
    o = '0;
    if (!r) begin
      m_phase = P_OFF; m_age = 0; m_votes = 0;
      for (int i = 0; i < 5; i++) begin
        m_s1[i] = 0; m_s[i] = 0; m_db[i] = 0; m_d1[i] = 0; m_d2[i] = 0;
        m_press[i] = 0; m_cnt[i] = 0;
      end
      exp_q.push_back(o);
      return;
    end
    // Ballot rules act on the presses and debounced levels from the previous cycle.
    if (!sw) begin
      m_phase = P_OFF; m_age = 0; m_votes = 0;
    end else begin
      case (m_phase)
        P_OFF:   m_phase = P_IDLE;
        P_IDLE:  if (m_press[0]) begin m_phase = P_ISSUE; o.cr = 1; end
                 else if (m_press[4]) begin m_phase = P_DONE; o.done = 1; end
        P_ISSUE: begin m_age = 0; m_phase = P_ARMED; end
        P_ARMED: begin
          n = int'(m_press[1]) + int'(m_press[2]) + int'(m_press[3]);
          if (n == 1) begin
            o.v1 = m_press[1]; o.v2 = m_press[2]; o.v3 = m_press[3];
            if (m_votes < 127) m_votes++;
            m_phase = P_COOL;
          end else begin
            if (n >= 2) o.merr = 1;
            if (m_age == T - 1) begin o.tmo = 1; m_phase = P_IDLE; end
            else m_age++;
          end
        end
        P_COOL:  if (!m_db[0] && !m_db[1] && !m_db[2] && !m_db[3]) m_phase = P_IDLE;
        default: ;
      endcase
    end
    o.armed = (m_phase == P_ARMED);
    o.cast  = 7'(m_votes);
    // Conditioning: press appears when db rose two cycles back.
    for (int i = 0; i < 5; i++) begin
      old_db = m_db[i]; old_d1 = m_d1[i];
      m_press[i] = m_d1[i] & ~m_d2[i];
      if (m_s[i] == m_db[i]) m_cnt[i] = 0;
      else if (m_cnt[i] == D - 1) begin m_db[i] = m_s[i]; m_cnt[i] = 0; end
      else m_cnt[i]++;
      m_s[i] = m_s1[i]; m_s1[i] = raw[i];
      m_d2[i] = old_d1; m_d1[i] = old_db;
    end
    exp_q.push_back(o);
  endtask

  // Apply one input pattern for n cycles and record the predicted response.
  task automatic drive(input bit r, input bit sw, input bit [4:0] raw, input int n);
    repeat (n) begin
      @(negedge clk);
      rst = r; switch_on_evm = sw;
      officer_btn_raw = raw[0]; cand_btn_raw = raw[3:1]; end_btn_raw = raw[4];
      model_step(r, sw, raw);
    end
  endtask

  // Monitor: compare the DUT output word against the oldest prediction.
  initial begin
    out_t got, e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        got = {candidate_ready, vote_candidate_1, vote_candidate_2, vote_candidate_3,
               voting_session_done, ballot_armed, multi_press_err, ballot_timeout, ballots_cast};
        n_cmp++;
        if (got !== e) begin
          n_bad++;
          $display("FAIL outputs @%0t: got cr%b v%b%b%b done%b arm%b merr%b tmo%b cast%0d, want cr%b v%b%b%b done%b arm%b merr%b tmo%b cast%0d",
                   $time, got.cr, got.v1, got.v2, got.v3, got.done, got.armed, got.merr, got.tmo, got.cast,
                   e.cr, e.v1, e.v2, e.v3, e.done, e.armed, e.merr, e.tmo, e.cast);
        end
      end
    end
  end

  // Stimulus: directed scenarios first, then randomized button activity.
  initial begin
    int sel;
    bit sw;
    rst = 0; switch_on_evm = 0; officer_btn_raw = 0; cand_btn_raw = 0; end_btn_raw = 0;
    drive(0, 0, 5'b00000, 3);
    drive(1, 1, 5'b00000, 5);
    // Officer issues, voter picks candidate 2.
    drive(1, 1, 5'b00001, 10); drive(1, 1, 5'b00000, 10);
    drive(1, 1, 5'b00100, 10); drive(1, 1, 5'b00000, 15);
    // Glitch on candidate 1, then a stable press.
    drive(1, 1, 5'b00001, 10); drive(1, 1, 5'b00000, 10);
    for (int k = 0; k < 3; k++) drive(1, 1, (k % 2 == 0) ? 5'b00010 : 5'b00000, 1);
    drive(1, 1, 5'b00010, 12); drive(1, 1, 5'b00000, 15);
    // Two candidates at once, then candidate 3.
    drive(1, 1, 5'b00001, 10); drive(1, 1, 5'b00000, 10);
    drive(1, 1, 5'b01010, 10); drive(1, 1, 5'b00000, 10);
    drive(1, 1, 5'b01000, 10); drive(1, 1, 5'b00000, 15);
    // Unused ballot times out.
    drive(1, 1, 5'b00001, 10); drive(1, 1, 5'b00000, 110);
    // Candidate 1 held through the next officer press.
    drive(1, 1, 5'b00001, 10); drive(1, 1, 5'b00000, 10);
    drive(1, 1, 5'b00010, 12); drive(1, 1, 5'b00011, 10);
    drive(1, 1, 5'b00010, 10); drive(1, 1, 5'b00000, 15);
    drive(1, 1, 5'b00001, 10); drive(1, 1, 5'b00000, 10);
    drive(1, 1, 5'b00100, 10); drive(1, 1, 5'b00000, 15);
    // Close session, ignored presses, power cycle.
    drive(1, 1, 5'b10000, 10); drive(1, 1, 5'b00000, 10);
    drive(1, 1, 5'b00001, 10); drive(1, 1, 5'b00000, 10);
    drive(1, 0, 5'b00000, 5);  drive(1, 1, 5'b00000, 5);
    // Mid-ballot reset.
    drive(1, 1, 5'b00001, 10); drive(1, 1, 5'b00000, 8);
    drive(0, 1, 5'b00000, 2);  drive(1, 1, 5'b00000, 5);
    // Randomized segments.
    sw = 1;
    for (int seg = 0; seg < 400; seg++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 3) sw = ~sw;
      if (sel < 25)       drive(1, sw, 5'b00001, int'($urandom_range(1, 12)));
      else if (sel < 55)  drive(1, sw, {1'b0, 3'($urandom_range(1, 7)), 1'b0}, int'($urandom_range(1, 15)));
      else if (sel < 60)  drive(1, sw, 5'b10000, int'($urandom_range(2, 10)));
      else if (sel < 62)  drive(0, sw, 5'b00000, int'($urandom_range(1, 3)));
      else if (sel < 66)  drive(1, sw, 5'($urandom_range(0, 31)), int'($urandom_range(1, 3)));
      else if (sel < 69)  drive(1, 1, 5'b00000, 100);
      else                drive(1, sw, 5'b00000, int'($urandom_range(3, 20)));
      if (sel < 3) sw = 1;
    end
    drive(1, 1, 5'b00000, 5);
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d predictions left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
